mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It consumes the decoder's start strobe and 4-bit MDU operation code, together with forwarded rs/rt operands. It owns the architectural HI/LO registers and models fixed multi-cycle latency through a busy flag, which the hazard unit uses to stall. It also supplies the mfhi/mflo read value to the EX result mux.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  operation strobe from decode: mult/multu/div/divu/mthi/mtlo
mduType  input  4  operation code (encodings under Decomposition)
srcA  input  32  rs operand (forwarded)
srcB  input  32  rt operand (forwarded)
busy  output  1  multi-cycle operation in flight
hi  output  32  architectural HI
lo  output  32  architectural LO
mduOut  output  32  hi if mduType==MFHI, lo if mduType==MFLO, else 0; combinational

Behaviour:
- Reset (reset_n=0, async): busy=0, hi=0, lo=0, internal counter=0, result temporaries=0. Reset overrides everything, including an operation in flight. No commit occurs after release.
- Idle means busy=0. start is sampled only at a rising edge while idle.
- MULT/MULTU accepted at edge E: operands latched, 64-bit product computed (signed / unsigned) into temporaries, busy<=1, counter<=MULT_CYCLES.
- DIV/DIVU accepted at edge E: quotient and remainder computed into temporaries, busy<=1, counter<=DIV_CYCLES.
- Busy window: busy is high for exactly N cycles after E (N = MULT_CYCLES or DIV_CYCLES). The counter decrements every edge while busy. At edge E+N: hi/lo take the temporaries and busy<=0. New values become visible in the cycle after E+N.
- Result placement:
  - mult/multu: hi=product[63:32], lo=product[31:0].
  - div/divu: lo=quotient, hi=remainder.
  - Signed div truncates toward zero; the remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (srcB==0, div or divu): the busy window runs normally; hi/lo are left unchanged at commit.
- MTHI/MTLO accepted at edge E: hi<=srcA (or lo<=srcA) at E itself; busy stays 0.
- mfhi/mflo: no state change; start is 0 for these (decoder guarantee). mduOut reads the current registers.
- start while busy: ignored entirely (no restart, no mthi/mtlo write). The hazard unit stalls on (start|busy) with an md/mf/mt code, so this is protocol misuse. The bench checks that it is ignored.
- start with an out-of-range or zero mduType: ignored.
- During busy, mduOut returns the pre-operation hi/lo (old values); stalling mf* is the hazard unit's job.
- Operands captured at acceptance: later srcA/srcB changes have no effect.

Decomposition:
- The shared constants header holds MDU op encodings: MDU_MULT=4'd1, MDU_MULTU=4'd2, MDU_DIV=4'd3, MDU_DIVU=4'd4, MDU_MFHI=4'd5, MDU_MFLO=4'd6, MDU_MTHI=4'd7, MDU_MTLO=4'd8, with 4'd0 meaning none. The decoder and this block both include it.
- No sub-module. One always block covers registers and counter; behavioural * / % on 33-bit sign/zero-extended operands yield the temporaries. The mduOut mux is a continuous assign.

Test Plan:
- Reset mid-divide: DIV start, then reset_n=0 at the 4th busy cycle -> busy=0, hi=lo=0 immediately (asynchronously); no commit afterwards.
- Signed multiply: MULT srcA=3, srcB=0xFFFFFFFE at edge E -> busy=1 for exactly 5 cycles; after E+5, hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- Unsigned multiply: MULTU srcA=srcB=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide: DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with DIVU 7/0 -> hi/lo unchanged, busy still high for 10 cycles.
- mthi/mtlo and reads: MTLO srcA=0x12345678 -> lo updated at that edge, busy never asserts. Then mduType=MFLO -> mduOut=0x12345678; mduType=MFHI -> mduOut=hi; mduType=0 -> mduOut=0.
- Start while busy: MULT accepted, then MTHI srcA=0xDEAD at busy cycle 2 and DIV at busy cycle 3 -> both ignored; hi/lo equal the MULT result at E+5, and busy drops exactly at E+5.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: operation encodings used by the decoder and the
// multiply/divide unit, plus a small helper to classify signed operations.
package mdu_unit_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  // Signed variants treat operands as two's complement.
  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage. Owns HI/LO, computes results at
// acceptance into temporaries and commits them after a fixed busy window.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  mduType,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mduOut
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sgn_s;
  logic [63:0]      a64_s, b64_s, prod_s;
  logic             neg_a_s, neg_b_s, div_zero_s;
  logic [31:0]      mag_a_s, mag_b_s, safe_b_s;
  logic [31:0]      uquot_s, urem_s, quot_s, rem_s;

  // Arithmetic datapath: full product and truncating quotient/remainder.
  always_comb begin
    sgn_s   = is_signed_op(mduType);
    a64_s   = sgn_s ? {{32{srcA[31]}}, srcA} : {32'd0, srcA};
    b64_s   = sgn_s ? {{32{srcB[31]}}, srcB} : {32'd0, srcB};
    // Low 64 bits of the product are identical for signed and unsigned
    // interpretation once operands are extended appropriately.
    prod_s  = a64_s * b64_s;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero and the remainder follows the dividend. 0x80000000 / -1 falls
    // out naturally as 0x80000000 with remainder 0.
    neg_a_s    = sgn_s & srcA[31];
    neg_b_s    = sgn_s & srcB[31];
    div_zero_s = (srcB == 32'd0);
    mag_a_s    = neg_a_s ? (32'd0 - srcA) : srcA;
    mag_b_s    = neg_b_s ? (32'd0 - srcB) : srcB;
    // Substitute a harmless divisor so the datapath never divides by zero;
    // the result is discarded at commit anyway.
    safe_b_s   = div_zero_s ? 32'd1 : mag_b_s;
    uquot_s    = mag_a_s / safe_b_s;
    urem_s     = mag_a_s % safe_b_s;
    quot_s     = (neg_a_s ^ neg_b_s) ? (32'd0 - uquot_s) : uquot_s;
    rem_s      = neg_a_s ? (32'd0 - urem_s) : urem_s;
  end

  // Next-state logic: accept operations when idle, count down and commit.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    busy_d   = busy_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    if (busy_q) begin
      // Any start while busy is protocol misuse and is ignored.
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        if (!dz_q) begin
          hi_d = tmp_hi_q;
          lo_d = tmp_lo_q;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end else begin
        busy_d = 1'b1;
      end
    end else if (start) begin
      case (mduType)
        MDU_MULT, MDU_MULTU: begin
          tmp_hi_d = prod_s[63:32];
          tmp_lo_d = prod_s[31:0];
          dz_d     = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = MULT_LOAD;
        end
        MDU_DIV, MDU_DIVU: begin
          tmp_hi_d = rem_s;
          tmp_lo_d = quot_s;
          dz_d     = div_zero_s;
          busy_d   = 1'b1;
          cnt_d    = DIV_LOAD;
        end
        MDU_MTHI: hi_d = srcA;
        MDU_MTLO: lo_d = srcA;
        default: begin
          // None, mf*, and unused codes leave state untouched.
          hi_d = hi_q;
        end
      endcase
    end else begin
      busy_d = 1'b0;
    end
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      busy_q   <= busy_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = busy_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  // Read mux for mfhi/mflo; returns committed values even while busy.
  assign mduOut = (mduType == MDU_MFHI) ? hi_q :
                  (mduType == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected commits, a monitor
// pops and compares whenever busy falls.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mduType = 4'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic        busy;
  logic [31:0] hi, lo, mduOut;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mduType(mduType),
    .srcA(srcA), .srcB(srcB), .busy(busy), .hi(hi), .lo(lo), .mduOut(mduOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one start strobe; it is sampled at the next rising edge (E).
  // Returns 1ns after E with operands scrambled to prove capture at E.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mduType = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; mduType = 4'd0; srcA = 32'h5A5A_A5A5; srcB = 32'h0F0F_F0F0;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h; e.lo = l; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) @(posedge clk);
    #1;
    n_vec++;
    if (busy) begin
      n_err++;
      $display("FAIL wait_idle: busy still 1 after 64 cycles, required 0");
    end
    @(posedge clk); #1;
  endtask

  // Monitor: counts busy cycles and checks the commit when busy falls.
  initial begin
    bit prev_busy = 1'b0;
    int busy_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_busy = 1'b0;
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
        prev_busy = 1'b1;
      end else begin
        if (prev_busy) begin
          if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_commit: hi=%h lo=%h with no expectation queued", hi, lo);
          end else begin
            e = sb_q.pop_front();
            check("commit_hi", hi, e.hi);
            check("commit_lo", lo, e.lo);
            check("busy_len", 32'(busy_cnt), 32'(e.cyc));
          end
        end
        prev_busy = 1'b0;
        busy_cnt = 0;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Signed and unsigned multiply
    push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(MDU_MULT, 32'd3, 32'hFFFF_FFFE);
    check("mult_busy_at_E", {31'd0, busy}, 32'd1);
    wait_idle();
    push(32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();

    // Divides, including divide-by-zero and the overflow case
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MDU_DIVU, 32'd7, 32'd0);
    wait_idle();
    push(32'h0000_0000, 32'h8000_0000, 10);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    push(32'h0000_0001, 32'h7FFF_FFFC, 10);
    issue(MDU_DIVU, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    push(32'h0000_0001, 32'hFFFF_FFFD, 10);
    issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle();

    // Moves and reads
    issue(MDU_MTLO, 32'h1234_5678, 32'd0);
    check("mtlo_lo", lo, 32'h1234_5678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    issue(MDU_MTHI, 32'hCAFE_BABE, 32'd0);
    check("mthi_hi", hi, 32'hCAFE_BABE);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    mduType = MDU_MFLO; #1;
    check("mflo_out", mduOut, 32'h1234_5678);
    mduType = MDU_MFHI; #1;
    check("mfhi_out", mduOut, 32'hCAFE_BABE);
    mduType = 4'd0; #1;
    check("none_out", mduOut, 32'd0);
    mduType = 4'd9; #1;
    check("bad_out", mduOut, 32'd0);
    mduType = 4'd0;

    // Start while busy: MTHI at E+2 and DIV at E+3 must be ignored
    push(32'h0000_0003, 32'h0000_0000, 5);
    issue(MDU_MULT, 32'h0001_0000, 32'h0003_0000);
    mduType = MDU_MFHI; #1;
    check("mfhi_during_busy", mduOut, 32'hCAFE_BABE);
    mduType = 4'd0;
    @(posedge clk); #1;
    issue(MDU_MTHI, 32'h0000_DEAD, 32'd0);
    check("mthi_ignored", hi, 32'hCAFE_BABE);
    issue(MDU_DIV, 32'd100, 32'd7);
    wait_idle();
    repeat (12) @(posedge clk);
    #1;
    check("no_late_div_busy", {31'd0, busy}, 32'd0);
    check("no_late_div_hi", hi, 32'h0000_0003);

    // Zero and out-of-range op codes are ignored
    issue(4'd0, 32'h1111_1111, 32'd2);
    check("op0_busy", {31'd0, busy}, 32'd0);
    issue(4'd12, 32'h2222_2222, 32'd2);
    check("op12_busy", {31'd0, busy}, 32'd0);
    check("badop_hi", hi, 32'h0000_0003);
    check("badop_lo", lo, 32'h0000_0000);

    // Reset in the 4th busy cycle of a divide: immediate clear, no commit
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);

    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
